ppwm_sched: RTL

Period scheduler and program-configuration controller for a bank of PWM execution units.
- Owns the global counter and generates the per-channel period-start pulses that restart each unit's program.
- Holds the period and channel-enable configuration in shadow registers; updates are applied only at period boundaries.
- Arbitrates program-memory writes so a channel's instructions are never modified while that channel is running.

---
 rtl/ppwm_sched.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ppwm_sched.sv
// Period scheduler and program-write arbiter for a bank of PWM execution units.
// Optional one-shot periods: define PPWM_SCHED_ONESHOT_EN to add cfg_oneshot_i.
module ppwm_sched #(
    parameter int NUM_CH               = 4,
    parameter int CH_IDX_WIDTH         = 2,
    parameter int GLOBAL_COUNTER_WIDTH = 20,
    parameter int INSTR_WIDTH          = 7,
    parameter int PC_WIDTH             = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            run_i,
    input  logic                            cfg_valid_i,
    output logic                            cfg_ready_o,
    input  logic [GLOBAL_COUNTER_WIDTH-1:0] cfg_period_i,
    input  logic [NUM_CH-1:0]               cfg_chan_en_i,
`ifdef PPWM_SCHED_ONESHOT_EN
    input  logic                            cfg_oneshot_i,
`endif
    output logic [NUM_CH-1:0]               start_o,
    output logic [GLOBAL_COUNTER_WIDTH-1:0] global_counter_o,
    output logic                            busy_o,
    input  logic                            prog_valid_i,
    output logic                            prog_ready_o,
    input  logic [CH_IDX_WIDTH-1:0]         prog_ch_i,
    input  logic [PC_WIDTH-1:0]             prog_addr_i,
    input  logic [INSTR_WIDTH-1:0]          prog_data_i,
    output logic                            mem_we_o,
    output logic [CH_IDX_WIDTH-1:0]         mem_ch_o,
    output logic [PC_WIDTH-1:0]             mem_addr_o,
    output logic [INSTR_WIDTH-1:0]          mem_data_o
);

    localparam int CW = GLOBAL_COUNTER_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]        period_q;
    logic [NUM_CH-1:0]    chan_en_q;
    logic                 pend_q;
    logic [CW-1:0]        pend_period_q;
    logic [NUM_CH-1:0]    pend_mask_q;
    logic                 wrap;
    logic                 cfg_fire;
    logic                 cfg_apply;
    logic                 run_go;
    logic                 oneshot_act;
    logic                 ch_ok;
    logic                 ch_en;

    logic                 mem_we_p1;
    logic [CH_IDX_WIDTH-1:0] mem_ch_p1;
    logic [PC_WIDTH-1:0]  mem_addr_p1;
    logic [INSTR_WIDTH-1:0] mem_data_p1;

    // Modulo-2**CW increment; wrap to zero at the programmed period end.
    function automatic logic [CW-1:0] next_count(input logic [CW-1:0] cnt, input logic at_wrap);
        if (at_wrap)
            return '0;
        return cnt + CW'(1);
    endfunction

    assign wrap      = (state_q != IDLE) && (cnt_q == period_q);
    assign cfg_fire  = cfg_valid_i & cfg_ready_o;
    // A pending config lands immediately when idle, otherwise only on a period wrap.
    assign cfg_apply = pend_q & ((state_q == IDLE) | wrap);

`ifdef PPWM_SCHED_ONESHOT_EN
    logic oneshot_q;
    logic pend_oneshot_q;
    logic run_d_q;

    assign oneshot_act = oneshot_q;
    assign run_go      = oneshot_q ? (run_i & ~run_d_q) : run_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            oneshot_q      <= 1'b0;
            pend_oneshot_q <= 1'b0;
            run_d_q        <= 1'b0;
        end else begin
            run_d_q <= run_i;
            if (cfg_fire)
                pend_oneshot_q <= cfg_oneshot_i;
            if (cfg_apply)
                oneshot_q <= pend_oneshot_q;
        end
    end
`else
    assign oneshot_act = 1'b0;
    assign run_go      = run_i;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (run_go)
                    state_d = RUN;
            end
            RUN: begin
                cnt_d = next_count(cnt_q, wrap);
                if (oneshot_act) begin
                    if (wrap)
                        state_d = IDLE;
                end else if (!run_i) begin
                    state_d = wrap ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                cnt_d = next_count(cnt_q, wrap);
                if (run_i)
                    state_d = RUN;
                else if (wrap)
                    state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            period_q      <= '0;
            chan_en_q     <= '0;
            pend_q        <= 1'b0;
            pend_period_q <= '0;
            pend_mask_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (cfg_fire) begin
                pend_q        <= 1'b1;
                pend_period_q <= cfg_period_i;
                pend_mask_q   <= cfg_chan_en_i;
            end else if (cfg_apply) begin
                pend_q <= 1'b0;
            end
            if (cfg_apply) begin
                period_q  <= pend_period_q;
                chan_en_q <= pend_mask_q;
            end
        end
    end

    assign cfg_ready_o      = ~rst & ~pend_q;
    assign start_o          = (state_q == RUN && cnt_q == '0) ? chan_en_q : '0;
    assign global_counter_o = cnt_q;
    assign busy_o           = (state_q != IDLE);

    // Channel lookup tolerates indices beyond NUM_CH (accepted but never written).
    always_comb begin
        ch_ok = 1'b0;
        ch_en = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (prog_ch_i == CH_IDX_WIDTH'(i)) begin
                ch_ok = 1'b1;
                ch_en = chan_en_q[i];
            end
        end
    end

    assign prog_ready_o = ~rst & prog_valid_i & ((state_q == IDLE) | ~ch_en);

    // Stage p1: registered program-memory write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we_p1   <= 1'b0;
            mem_ch_p1   <= '0;
            mem_addr_p1 <= '0;
            mem_data_p1 <= '0;
        end else begin
            mem_we_p1 <= prog_ready_o & ch_ok;
            if (prog_ready_o) begin
                mem_ch_p1   <= prog_ch_i;
                mem_addr_p1 <= prog_addr_i;
                mem_data_p1 <= prog_data_i;
            end
        end
    end

    assign mem_we_o   = mem_we_p1;
    assign mem_ch_o   = mem_ch_p1;
    assign mem_addr_o = mem_addr_p1;
    assign mem_data_o = mem_data_p1;

endmodule
